// File: rtl/filt_pkg.sv
// Shared definitions for the border-mask post-filter stage: lock FSM state
// encodings and default geometry parameters used by the top and its
// active-area measurement sub-block.
package filt_pkg;

    // Default edge width to mask (half of the 5x5 kernel).
    localparam int FILT_BORDER_DEF = 2;

    // Default width of the column/line counters.
    localparam int FILT_CNT_W_DEF  = 12;

    // Lock state machine encodings.
    typedef enum logic [1:0] {
        ST_WAIT_VS = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_e;

endpackage : filt_pkg

// File: rtl/filt_border_mask_active_area_meas.sv
// Active-area measurement: detects vs rising / dv falling edges, keeps the
// column and line counters, captures the first-line width of each frame and
// flags any later line whose width differs. At a frame end it presents the
// final width/height/error of the ending frame, including a line that ends
// on that very cycle.
module active_area_meas
    import filt_pkg::*;
#(
    parameter int CNT_W  = FILT_CNT_W_DEF,
    parameter int BORDER = FILT_BORDER_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_dv,
    input  logic             rx_vs,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             frame_end,
    output logic             frame_ok,
    output logic [CNT_W-1:0] frame_w,
    output logic [CNT_W-1:0] frame_h,
    output logic             frame_w_err
);

    localparam logic [CNT_W-1:0] ZERO_C    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] MIN_DIM_C = CNT_W'(2 * BORDER + 1);

    // Saturating increment for the counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX_C) begin
            sat_inc = v;
        end else begin
            sat_inc = v + ONE_C;
        end
    endfunction

    logic             vs_d_r;
    logic             dv_d_r;
    logic [CNT_W-1:0] x_r;
    logic [CNT_W-1:0] y_r;
    logic [CNT_W-1:0] ref_w_r;
    logic             w_err_r;

    logic             vs_rise_s;
    logic             dv_fall_s;
    logic             first_line_s;
    logic [CNT_W-1:0] y_fin_s;
    logic [CNT_W-1:0] w_fin_s;
    logic             w_err_fin_s;

    assign vs_rise_s    = rx_vs & ~vs_d_r;
    assign dv_fall_s    = ~rx_dv & dv_d_r;
    assign first_line_s = (y_r == ZERO_C);

    // Frame totals as they stand after counting a line that ends this cycle,
    // so a line ending together with vs_rise still belongs to the old frame.
    always_comb begin
        y_fin_s     = y_r;
        w_fin_s     = ref_w_r;
        w_err_fin_s = w_err_r;
        if (dv_fall_s) begin
            y_fin_s = sat_inc(y_r);
            if (first_line_s) begin
                w_fin_s = x_r;
            end else begin
                w_err_fin_s = w_err_r | (x_r != ref_w_r);
            end
        end else begin
            y_fin_s = y_r;
        end
    end

    // Previous-cycle copies of vs and dv for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vs_d_r <= 1'b0;
            dv_d_r <= 1'b0;
        end else begin
            vs_d_r <= rx_vs;
            dv_d_r <= rx_dv;
        end
    end

    // Column counter: counts active pixels of the current line, holds the
    // final width through the dv falling cycle, cleared during blanking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_r <= ZERO_C;
        end else if (!rx_dv) begin
            x_r <= ZERO_C;
        end else begin
            x_r <= sat_inc(x_r);
        end
    end

    // Line counter, reference width and sticky width error, restarted at
    // every frame start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            y_r     <= ZERO_C;
            ref_w_r <= ZERO_C;
            w_err_r <= 1'b0;
        end else if (vs_rise_s) begin
            y_r     <= ZERO_C;
            ref_w_r <= ZERO_C;
            w_err_r <= 1'b0;
        end else begin
            y_r     <= y_fin_s;
            ref_w_r <= w_fin_s;
            w_err_r <= w_err_fin_s;
        end
    end

    assign x           = x_r;
    assign y           = y_r;
    assign frame_end   = vs_rise_s;
    assign frame_w     = w_fin_s;
    assign frame_h     = y_fin_s;
    assign frame_w_err = w_err_fin_s;
    assign frame_ok    = ~w_err_fin_s & (w_fin_s >= MIN_DIM_C) & (y_fin_s >= MIN_DIM_C);

endmodule : active_area_meas

// File: rtl/filt_border_mask.sv
// Border mask stage behind the 5x5 convolution filter. Learns the active
// area from the dv/hs/vs stream, locks after a fully consistent measured
// frame, and while locked and enabled replaces the BORDER-wide frame edge
// with MASK_VAL. Pixels and sync flags leave through one register stage.
module filt_border_mask
    import filt_pkg::*;
#(
    parameter int         BORDER   = FILT_BORDER_DEF,
    parameter int         CNT_W    = FILT_CNT_W_DEF,
    parameter logic [7:0] MASK_VAL = 8'h00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [7:0]       rx_red,
    input  logic [7:0]       rx_green,
    input  logic [7:0]       rx_blue,
    input  logic             rx_dv,
    input  logic             rx_hs,
    input  logic             rx_vs,
    output logic [7:0]       tx_red,
    output logic [7:0]       tx_green,
    output logic [7:0]       tx_blue,
    output logic             tx_dv,
    output logic             tx_hs,
    output logic             tx_vs,
    output logic             locked,
    output logic [CNT_W-1:0] act_w,
    output logic [CNT_W-1:0] act_h
);

    localparam logic [CNT_W-1:0] ZERO_C   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] BORDER_C = CNT_W'(BORDER);

    logic [CNT_W-1:0] x_s;
    logic [CNT_W-1:0] y_s;
    logic             frame_end_s;
    logic             frame_ok_s;
    logic [CNT_W-1:0] frame_w_s;
    logic [CNT_W-1:0] frame_h_s;
    logic             frame_w_err_s;

    state_e           state_r;
    state_e           state_nxt_s;
    logic [CNT_W-1:0] act_w_r;
    logic [CNT_W-1:0] act_w_nxt_s;
    logic [CNT_W-1:0] act_h_r;
    logic [CNT_W-1:0] act_h_nxt_s;
    logic             locked_r;

    logic             edge_s;
    logic             mask_s;

    logic [7:0]       tx_red_r;
    logic [7:0]       tx_green_r;
    logic [7:0]       tx_blue_r;
    logic             tx_dv_r;
    logic             tx_hs_r;
    logic             tx_vs_r;

    active_area_meas #(
        .CNT_W  (CNT_W),
        .BORDER (BORDER)
    ) u_meas (
        .clk         (clk),
        .rst         (rst),
        .rx_dv       (rx_dv),
        .rx_vs       (rx_vs),
        .x           (x_s),
        .y           (y_s),
        .frame_end   (frame_end_s),
        .frame_ok    (frame_ok_s),
        .frame_w     (frame_w_s),
        .frame_h     (frame_h_s),
        .frame_w_err (frame_w_err_s)
    );

    // Lock FSM next state and latched geometry, evaluated at each frame end.
    always_comb begin
        state_nxt_s = state_r;
        act_w_nxt_s = act_w_r;
        act_h_nxt_s = act_h_r;
        case (state_r)
            ST_WAIT_VS: begin
                if (frame_end_s) begin
                    state_nxt_s = ST_MEASURE;
                end else begin
                    state_nxt_s = ST_WAIT_VS;
                end
            end
            ST_MEASURE: begin
                if (frame_end_s && frame_ok_s) begin
                    state_nxt_s = ST_LOCKED;
                    act_w_nxt_s = frame_w_s;
                    act_h_nxt_s = frame_h_s;
                end else begin
                    state_nxt_s = ST_MEASURE;
                end
            end
            ST_LOCKED: begin
                if (frame_end_s && (frame_w_err_s || (frame_w_s != act_w_r) ||
                                    (frame_h_s != act_h_r))) begin
                    state_nxt_s = ST_MEASURE;
                    act_w_nxt_s = ZERO_C;
                    act_h_nxt_s = ZERO_C;
                end else begin
                    state_nxt_s = ST_LOCKED;
                end
            end
            default: begin
                state_nxt_s = ST_WAIT_VS;
                act_w_nxt_s = ZERO_C;
                act_h_nxt_s = ZERO_C;
            end
        endcase
    end

    // Lock FSM state, geometry and lock flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_WAIT_VS;
            act_w_r  <= ZERO_C;
            act_h_r  <= ZERO_C;
            locked_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            act_w_r  <= act_w_nxt_s;
            act_h_r  <= act_h_nxt_s;
            locked_r <= (state_nxt_s == ST_LOCKED);
        end
    end

    // Per-pixel border decision; out-of-range pixels/lines also fall in the
    // edge test so an oversized frame stays masked until it unlocks.
    always_comb begin
        edge_s = (x_s <  BORDER_C) ||
                 (x_s >= (act_w_r - BORDER_C)) ||
                 (y_s <  BORDER_C) ||
                 (y_s >= (act_h_r - BORDER_C));
        if (locked_r && en && rx_dv) begin
            mask_s = edge_s;
        end else begin
            mask_s = 1'b0;
        end
    end

    // Output stage: one cycle of latency for pixels and all sync flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_red_r   <= 8'h00;
            tx_green_r <= 8'h00;
            tx_blue_r  <= 8'h00;
            tx_dv_r    <= 1'b0;
            tx_hs_r    <= 1'b0;
            tx_vs_r    <= 1'b0;
        end else begin
            tx_red_r   <= mask_s ? MASK_VAL : rx_red;
            tx_green_r <= mask_s ? MASK_VAL : rx_green;
            tx_blue_r  <= mask_s ? MASK_VAL : rx_blue;
            tx_dv_r    <= rx_dv;
            tx_hs_r    <= rx_hs;
            tx_vs_r    <= rx_vs;
        end
    end

    assign tx_red   = tx_red_r;
    assign tx_green = tx_green_r;
    assign tx_blue  = tx_blue_r;
    assign tx_dv    = tx_dv_r;
    assign tx_hs    = tx_hs_r;
    assign tx_vs    = tx_vs_r;
    assign locked   = locked_r;
    assign act_w    = act_w_r;
    assign act_h    = act_h_r;

endmodule : filt_border_mask

// File: tb/tb_filt_border_mask.sv
// Bench for filt_border_mask: frame-level stimulus with random pixel data,
// a queue-based reference model of geometry learning and edge masking, a
// per-cycle compare of every output, and literal expectations for lock
// timing, latched geometry and masked/unmasked pixel counts.
module tb_filt_border_mask;

    localparam int         BORDER   = 2;
    localparam int         CNT_W    = 12;
    localparam logic [7:0] MASK_VAL = 8'h00;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             en;
    logic [7:0]       rx_red, rx_green, rx_blue;
    logic             rx_dv, rx_hs, rx_vs;
    logic [7:0]       tx_red, tx_green, tx_blue;
    logic             tx_dv, tx_hs, tx_vs;
    logic             locked;
    logic [CNT_W-1:0] act_w, act_h;

    filt_border_mask #(
        .BORDER   (BORDER),
        .CNT_W    (CNT_W),
        .MASK_VAL (MASK_VAL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .rx_red   (rx_red),
        .rx_green (rx_green),
        .rx_blue  (rx_blue),
        .rx_dv    (rx_dv),
        .rx_hs    (rx_hs),
        .rx_vs    (rx_vs),
        .tx_red   (tx_red),
        .tx_green (tx_green),
        .tx_blue  (tx_blue),
        .tx_dv    (tx_dv),
        .tx_hs    (tx_hs),
        .tx_vs    (tx_vs),
        .locked   (locked),
        .act_w    (act_w),
        .act_h    (act_h)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int px_pass = 0;
    int px_mask = 0;
    bit chk_on = 1'b0;

    // ---------------- reference model ----------------
    // phase: 0 waiting for first frame start, 1 measuring, 2 locked
    int   m_phase = 0;
    int   m_col   = 0;
    int   m_widths[$];
    logic m_pvs = 1'b0, m_pdv = 1'b0;
    int   m_aw = 0, m_ah = 0;
    logic [7:0] e_r = 8'h00, e_g = 8'h00, e_b = 8'h00;
    logic e_dv = 1'b0, e_hs = 1'b0, e_vs = 1'b0, e_lk = 1'b0;
    int   e_aw = 0, e_ah = 0;

    task automatic model_reset();
        m_phase = 0; m_col = 0; m_widths.delete();
        m_pvs = 1'b0; m_pdv = 1'b0; m_aw = 0; m_ah = 0;
        e_r = 8'h00; e_g = 8'h00; e_b = 8'h00;
        e_dv = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_lk = 1'b0; e_aw = 0; e_ah = 0;
    endtask

    task automatic model_step();
        bit vr, df, mk, same;
        int ln, h, w;
        vr = rx_vs && !m_pvs;
        df = !rx_dv && m_pdv;
        ln = m_widths.size();
        mk = (m_phase == 2) && en && rx_dv &&
             (m_col < BORDER || m_col >= m_aw - BORDER || ln < BORDER || ln >= m_ah - BORDER);
        e_r  = mk ? MASK_VAL : rx_red;
        e_g  = mk ? MASK_VAL : rx_green;
        e_b  = mk ? MASK_VAL : rx_blue;
        e_dv = rx_dv; e_hs = rx_hs; e_vs = rx_vs;
        if (df) m_widths.push_back(m_col);
        m_col = rx_dv ? m_col + 1 : 0;
        if (vr) begin
            h = m_widths.size();
            w = (h > 0) ? m_widths[0] : 0;
            same = 1'b1;
            foreach (m_widths[i]) if (m_widths[i] != w) same = 1'b0;
            if (m_phase == 0) begin
                m_phase = 1;
            end else if (m_phase == 1) begin
                if (same && w >= 2*BORDER+1 && h >= 2*BORDER+1) begin
                    m_phase = 2; m_aw = w; m_ah = h;
                end
            end else begin
                if (!same || w != m_aw || h != m_ah) begin
                    m_phase = 1; m_aw = 0; m_ah = 0;
                end
            end
            m_widths.delete();
        end
        m_pvs = rx_vs; m_pdv = rx_dv;
        e_lk = (m_phase == 2); e_aw = m_aw; e_ah = m_ah;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) model_reset();
        else      model_step();
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic compare_all();
        check("pixel", {8'h00, tx_red, tx_green, tx_blue}, {8'h00, e_r, e_g, e_b});
        check("flags", {29'h0, tx_dv, tx_hs, tx_vs}, {29'h0, e_dv, e_hs, e_vs});
        check("geom",  {7'h00, locked, act_w, act_h}, {7'h00, e_lk, 12'(e_aw), 12'(e_ah)});
        if (tx_dv && tx_red == 8'hA5) px_pass++;
        if (tx_dv && tx_red == 8'h00) px_mask++;
    endtask

    // One clock: compare on the falling edge, then advance past the rising edge.
    task automatic step();
        @(negedge clk);
        if (chk_on) compare_all();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input int w, input int h, input int bad_line, input int bad_w,
                         input logic [7:0] fixed, input int rst_line, input bit rand_en,
                         output logic lk_before, output logic lk_after);
        int lw;
        rx_vs = 1'b1; rx_hs = 1'b0; rx_dv = 1'b0;
        lk_before = locked;
        step();
        lk_after = locked;
        step();
        rx_vs = 1'b0;
        repeat (3) step();
        for (int l = 0; l < h; l++) begin
            rx_hs = 1'b1; repeat (2) step();
            rx_hs = 1'b0; repeat (2) step();
            lw = (l == bad_line) ? bad_w : w;
            for (int p = 0; p < lw; p++) begin
                rx_dv = 1'b1;
                if (fixed != 8'h00) begin
                    rx_red = fixed; rx_green = fixed; rx_blue = fixed;
                end else begin
                    rx_red   = 8'($urandom_range(0, 255));
                    rx_green = 8'($urandom_range(0, 255));
                    rx_blue  = 8'($urandom_range(0, 255));
                end
                if (rand_en) en = 1'($urandom_range(0, 1));
                if (l == rst_line && p == lw / 2) begin
                    #2 rst = 1'b0;
                    #1;
                    check("rst_tx_pix", {8'h00, tx_red, tx_green, tx_blue}, 32'h0);
                    check("rst_tx_flags", {29'h0, tx_dv, tx_hs, tx_vs}, 32'h0);
                    check("rst_locked", {31'h0, locked}, 32'h0);
                    step(); step();
                    rst = 1'b1;
                end else begin
                    step();
                end
            end
            rx_dv = 1'b0; repeat (2) step();
        end
        repeat (3) step();
        if (rand_en) en = 1'b1;
    endtask

    initial begin
        logic b, a;
        int p0, q0;
        rst = 1'b0; en = 1'b1;
        rx_red = 8'h5A; rx_green = 8'h5A; rx_blue = 8'h5A;
        rx_dv = 1'b1; rx_hs = 1'b1; rx_vs = 1'b1;
        step(); step();
        chk_on = 1'b1;
        step();
        check("reset_tx",     {8'h00, tx_red, tx_green, tx_blue}, 32'h0);
        check("reset_flags",  {29'h0, tx_dv, tx_hs, tx_vs}, 32'h0);
        check("reset_locked", {31'h0, locked}, 32'h0);
        check("reset_geom",   {8'h00, act_w, act_h}, 32'h0);
        rx_dv = 1'b0; rx_hs = 1'b0; rx_vs = 1'b0;
        step();
        rst = 1'b1;
        step(); step();

        // Lock on an 8x6 stream
        frame(8, 6, -1, 0, 8'h00, -1, 1'b0, b, a);
        check("f1_lk_after", {31'h0, a}, 32'h0);
        frame(8, 6, -1, 0, 8'h00, -1, 1'b0, b, a);
        check("f2_lk_before", {31'h0, b}, 32'h0);
        check("f2_lk_after",  {31'h0, a}, 32'h1);
        check("act_w", 32'(act_w), 32'd8);
        check("act_h", 32'(act_h), 32'd6);
        p0 = px_pass; q0 = px_mask;
        frame(8, 6, -1, 0, 8'hA5, -1, 1'b0, b, a);
        check("f3_unmasked", 32'(px_pass - p0), 32'd8);
        check("f3_masked",   32'(px_mask - q0), 32'd40);

        // Mask disabled: bit-exact passthrough
        en = 1'b0;
        frame(8, 6, -1, 0, 8'h00, -1, 1'b0, b, a);
        p0 = px_pass;
        frame(8, 6, -1, 0, 8'hA5, -1, 1'b0, b, a);
        check("en0_unmasked", 32'(px_pass - p0), 32'd48);
        en = 1'b1;

        // One frame with a short line 3
        frame(8, 6, 3, 7, 8'h00, -1, 1'b0, b, a);
        check("bad_lk_after", {31'h0, a}, 32'h1);
        frame(8, 6, -1, 0, 8'h00, -1, 1'b0, b, a);
        check("unlock_after_bad", {31'h0, a}, 32'h0);
        frame(8, 6, -1, 0, 8'h00, -1, 1'b0, b, a);
        check("relock", {31'h0, a}, 32'h1);

        // Too narrow to lock
        frame(4, 6, -1, 0, 8'h00, -1, 1'b0, b, a);
        frame(4, 6, -1, 0, 8'h00, -1, 1'b0, b, a);
        check("narrow_unlock", {31'h0, a}, 32'h0);
        p0 = px_pass;
        frame(4, 6, -1, 0, 8'hA5, -1, 1'b0, b, a);
        check("narrow_stays0", {31'h0, a}, 32'h0);
        check("narrow_unmasked", 32'(px_pass - p0), 32'd24);
        frame(8, 6, -1, 0, 8'h00, -1, 1'b0, b, a);
        check("narrow_still0", {31'h0, a}, 32'h0);

        // Relock, then reset mid-frame
        frame(8, 6, -1, 0, 8'h00, -1, 1'b0, b, a);
        check("pre_rst_lock", {31'h0, a}, 32'h1);
        frame(8, 6, -1, 0, 8'h00, 2, 1'b0, b, a);
        p0 = px_pass;
        frame(8, 6, -1, 0, 8'hA5, -1, 1'b0, b, a);
        check("post_rst_vs1", {31'h0, a}, 32'h0);
        check("post_rst_unmasked", 32'(px_pass - p0), 32'd48);
        frame(8, 6, -1, 0, 8'h00, -1, 1'b0, b, a);
        check("post_rst_vs2", {31'h0, a}, 32'h1);

        // Random per-pixel enable toggling and random data
        frame(8, 6, -1, 0, 8'h00, -1, 1'b1, b, a);
        frame(8, 6, -1, 0, 8'h00, -1, 1'b1, b, a);
        // Random geometry changes
        for (int k = 0; k < 4; k++) begin
            int rw, rh;
            rw = $urandom_range(5, 10);
            rh = $urandom_range(4, 8);
            frame(rw, rh, -1, 0, 8'h00, -1, 1'b1, b, a);
            frame(rw, rh, -1, 0, 8'h00, -1, 1'b0, b, a);
        end
        frame(8, 6, -1, 0, 8'h00, -1, 1'b0, b, a);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_filt_border_mask
